// File: rtl/exu_sequencer.sv
// Execution sequencer between IDU and WBU: routes ops to ALU or iterative MDU.
// Optional MDU watchdog enabled by defining EXU_SEQ_TIMEOUT_EN.
module exu_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic        in_is_mdu,
    input  logic        in_ebreak,
    input  logic        in_invalid,
    input  logic [63:0] alu_result,
    output logic        mdu_start,
    input  logic        mdu_done,
    input  logic [63:0] mdu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [63:0] out_rd_data,
    output logic        halt,
    output logic        halt_abort,
    output logic [63:0] halt_pc,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MDU,
        OUT,
        HALT
    } state_e;

    state_e      state_q;
    logic        in_ready_q;
    logic        mdu_start_q;
    logic        out_valid_q;
    logic        halt_q;
    logic        halt_abort_q;
    logic [63:0] pc_q;
    logic [63:0] data_q;
    logic [63:0] halt_pc_q;
    logic [31:0] retire_cnt_q;

    logic accept;
    logic done_ok;

    assign accept  = in_ready_q & in_valid;
    // A done pulse coincident with our own start pulse belongs to no request.
    assign done_ok = mdu_done & ~mdu_start_q;

`ifdef EXU_SEQ_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        tmo_hit;
    assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            mdu_start_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            halt_q       <= 1'b0;
            halt_abort_q <= 1'b0;
            pc_q         <= 64'd0;
            data_q       <= 64'd0;
            halt_pc_q    <= 64'd0;
            retire_cnt_q <= 32'd0;
`ifdef EXU_SEQ_TIMEOUT_EN
            tmo_q        <= 16'd0;
`endif
        end else begin
            mdu_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        pc_q       <= in_pc;
                        if (in_invalid) begin
                            state_q      <= HALT;
                            halt_q       <= 1'b1;
                            halt_abort_q <= 1'b1;
                            halt_pc_q    <= in_pc;
                        end else if (in_ebreak) begin
                            state_q      <= HALT;
                            halt_q       <= 1'b1;
                            halt_abort_q <= 1'b0;
                            halt_pc_q    <= in_pc;
                        end else if (in_is_mdu) begin
                            state_q     <= WAIT_MDU;
                            mdu_start_q <= 1'b1;
`ifdef EXU_SEQ_TIMEOUT_EN
                            tmo_q       <= 16'd0;
`endif
                        end else begin
                            state_q     <= OUT;
                            data_q      <= alu_result;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                WAIT_MDU: begin
                    if (done_ok) begin
                        state_q     <= OUT;
                        data_q      <= mdu_result;
                        out_valid_q <= 1'b1;
`ifdef EXU_SEQ_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_q      <= HALT;
                        halt_q       <= 1'b1;
                        halt_abort_q <= 1'b1;
                        halt_pc_q    <= pc_q;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
`endif
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        retire_cnt_q <= retire_cnt_q + 32'd1;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign mdu_start   = mdu_start_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = pc_q;
    assign out_rd_data = data_q;
    assign halt        = halt_q;
    assign halt_abort  = halt_abort_q;
    assign halt_pc     = halt_pc_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_exu_sequencer.sv
// Randomized self-checking bench for exu_sequencer against a
// transaction-level timing/result model.
module tb_exu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic        in_is_mdu = 1'b0;
    logic        in_ebreak = 1'b0;
    logic        in_invalid = 1'b0;
    logic [63:0] alu_result = '0;
    logic        mdu_start;
    logic        mdu_done = 1'b0;
    logic [63:0] mdu_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [63:0] out_rd_data;
    logic        halt;
    logic        halt_abort;
    logic [63:0] halt_pc;
    logic [31:0] retire_cnt;

    int          passed = 0;
    int          total = 0;
    logic [31:0] rc_model = 0;

    localparam int TMO = 8;

    always #5 clk = ~clk;

    exu_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_is_mdu(in_is_mdu), .in_ebreak(in_ebreak),
        .in_invalid(in_invalid), .alu_result(alu_result),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .mdu_result(mdu_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc),
        .out_rd_data(out_rd_data), .halt(halt),
        .halt_abort(halt_abort), .halt_pc(halt_pc),
        .retire_cnt(retire_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic pulse_reset();
        #3 rst = 1'b0;
        #4 rst = 1'b1;
        rc_model = 0;
        step();
    endtask

    // Drives one op and measures what the DUT did; comparisons are made by callers.
    task automatic run_op(
        input  bit mdu, input logic [63:0] pc, alu, mres,
        input  int k, stall, input bit early,
        output int lat, starts, start_at, ret_c,
        output bit busy_ok, stable,
        output logic [63:0] opc, odat, output logic [31:0] rc_after
    );
        int first;
        bit ok;
        lat = -1; starts = 0; start_at = -1; ret_c = -1;
        busy_ok = 1'b1; stable = 1'b1; first = -1;
        opc = 'x; odat = 'x; rc_after = 'x;
        wait_idle(ok);
        if (!ok) return;
        in_valid = 1'b1; in_pc = pc; alu_result = alu;
        in_is_mdu = mdu; in_ebreak = 1'b0; in_invalid = 1'b0;
        out_ready = (stall == 0);
        step();
        in_valid = 1'b0;
        in_pc = {$urandom, $urandom};
        alu_result = {$urandom, $urandom};
        for (int c = 1; c < 400; c++) begin
            if (mdu_start === 1'b1) begin
                starts++;
                start_at = c;
            end
            if (out_valid !== 1'b1 && first >= 0) begin
                ret_c = c;
                rc_after = retire_cnt;
                if (in_ready !== 1'b1) busy_ok = 1'b0;
                break;
            end
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            if (out_valid === 1'b1) begin
                if (first < 0) begin
                    first = c; lat = c; opc = out_pc; odat = out_rd_data;
                end else if (out_pc !== opc || out_rd_data !== odat) begin
                    stable = 1'b0;
                end
                if (c - first >= stall) out_ready = 1'b1;
            end
            mdu_done = mdu && ((c == k + 1) || (early && c == 1));
            mdu_result = (c == k + 1) ? mres : ~mres;
            step();
        end
        mdu_done = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0 || mdu_start !== 1'b0) $display("FAIL rst_valid got %b/%b want 0/0", out_valid, mdu_start); else passed++;
        total++; if (halt !== 1'b0 || halt_abort !== 1'b0 || halt_pc !== 64'd0) $display("FAIL rst_halt got %b/%b/%h want 0", halt, halt_abort, halt_pc); else passed++;
        total++; if (retire_cnt !== 32'd0 || out_pc !== 64'd0 || out_rd_data !== 64'd0) $display("FAIL rst_out got %h/%h/%h want 0", retire_cnt, out_pc, out_rd_data); else passed++;
        #10 rst = 1'b1;
        step();
    endtask

    task automatic test_alu();
        int lat, st, sa, rt; bit bz, stb; logic [63:0] opc, od; logic [31:0] rc;
        run_op(1'b0, 64'h8000_0000, 64'h1234, 64'h0, 0, 0, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        rc_model++;
        total++; if (lat !== 1) $display("FAIL alu_lat got %0d want 1", lat); else passed++;
        total++; if (od !== 64'h1234 || opc !== 64'h8000_0000) $display("FAIL alu_out got %h/%h want 1234/80000000", od, opc); else passed++;
        total++; if (rc !== rc_model) $display("FAIL alu_retire got %0d want %0d", rc, rc_model); else passed++;
        total++; if (st !== 0 || !bz) $display("FAIL alu_ctl got start=%0d busy_ok=%b want 0/1", st, bz); else passed++;
    endtask

    task automatic test_mdu();
        int lat, st, sa, rt; bit bz, stb; logic [63:0] opc, od; logic [31:0] rc;
        run_op(1'b1, 64'h8000_0004, 64'h5555, 64'hDEAD, 5, 0, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        rc_model++;
        total++; if (st !== 1 || sa !== 1) $display("FAIL mdu_start got n=%0d at %0d want 1 at 1", st, sa); else passed++;
        total++; if (lat !== 7) $display("FAIL mdu_lat got %0d want 7", lat); else passed++;
        total++; if (od !== 64'hDEAD || opc !== 64'h8000_0004) $display("FAIL mdu_out got %h/%h want dead/80000004", od, opc); else passed++;
        total++; if (!bz || rc !== rc_model) $display("FAIL mdu_ready got busy_ok=%b rc=%0d want 1/%0d", bz, rc, rc_model); else passed++;
    endtask

    task automatic test_backpressure();
        int lat, st, sa, rt; bit bz, stb; logic [63:0] opc, od; logic [31:0] rc;
        run_op(1'b0, 64'h8000_0008, 64'hCAFE_F00D, 64'h0, 0, 10, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        rc_model++;
        total++; if (!stb || !bz) $display("FAIL bp_stable got stable=%b busy_ok=%b want 1/1", stb, bz); else passed++;
        total++; if (rt !== 12) $display("FAIL bp_retire_cycle got %0d want 12", rt); else passed++;
        total++; if (od !== 64'hCAFE_F00D || rc !== rc_model) $display("FAIL bp_out got %h rc=%0d want cafef00d/%0d", od, rc, rc_model); else passed++;
    endtask

    task automatic test_random();
        int lat, st, sa, rt; bit bz, stb; logic [63:0] opc, od; logic [31:0] rc;
        bit mdu, early; int k, stall; logic [63:0] pc, alu, mres, exp_d; int exp_lat;
        for (int i = 0; i < 16; i++) begin
            mdu = 1'($urandom_range(0, 1));
            early = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 6);
            stall = $urandom_range(0, 3);
            pc = {$urandom, $urandom}; alu = {$urandom, $urandom}; mres = {$urandom, $urandom};
            run_op(mdu, pc, alu, mres, k, stall, early, lat, st, sa, rt, bz, stb, opc, od, rc);
            exp_lat = mdu ? k + 2 : 1;
            exp_d = mdu ? mres : alu;
            rc_model++;
            total++; if (lat !== exp_lat) $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, exp_lat); else passed++;
            total++; if (od !== exp_d || opc !== pc) $display("FAIL rnd%0d_out got %h/%h want %h/%h", i, od, opc, exp_d, pc); else passed++;
            total++; if (rc !== rc_model || rt !== exp_lat + stall + 1) $display("FAIL rnd%0d_retire got %0d@%0d want %0d@%0d", i, rc, rt, rc_model, exp_lat + stall + 1); else passed++;
            total++; if (st !== int'(mdu) || !bz || !stb) $display("FAIL rnd%0d_ctl got start=%0d busy_ok=%b stable=%b want %0d/1/1", i, st, bz, stb, mdu); else passed++;
        end
    endtask

    task automatic test_halt();
        bit ok, held;
        logic [31:0] rc0;
        wait_idle(ok);
        rc0 = retire_cnt;
        in_valid = 1'b1; in_pc = 64'h8000_0010; in_ebreak = 1'b1;
        in_is_mdu = 1'b1; in_invalid = 1'b0;
        step();
        in_ebreak = 1'b0; in_is_mdu = 1'b0;
        total++; if (halt !== 1'b1 || halt_abort !== 1'b0 || halt_pc !== 64'h8000_0010) $display("FAIL ebreak got %b/%b/%h want 1/0/80000010", halt, halt_abort, halt_pc); else passed++;
        held = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_pc = {$urandom, $urandom};
            mdu_done = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            if (out_valid !== 1'b0 || mdu_start !== 1'b0 || in_ready !== 1'b0) held = 1'b0;
            if (halt !== 1'b1 || halt_abort !== 1'b0 || halt_pc !== 64'h8000_0010 || retire_cnt !== rc0) held = 1'b0;
            step();
        end
        in_valid = 1'b0; mdu_done = 1'b0; out_ready = 1'b0;
        total++; if (!held) $display("FAIL halt_absorb got held=0 want 1"); else passed++;
        pulse_reset();
        total++; if (halt !== 1'b0 || retire_cnt !== 32'd0) $display("FAIL halt_clear got %b/%0d want 0/0", halt, retire_cnt); else passed++;
        wait_idle(ok);
        in_valid = 1'b1; in_pc = 64'h8000_0020; in_invalid = 1'b1; in_ebreak = 1'b1;
        step();
        in_valid = 1'b0; in_invalid = 1'b0; in_ebreak = 1'b0;
        total++; if (halt !== 1'b1 || halt_abort !== 1'b1 || halt_pc !== 64'h8000_0020 || out_valid !== 1'b0) $display("FAIL invalid got %b/%b/%h ov=%b want 1/1/80000020 ov=0", halt, halt_abort, halt_pc, out_valid); else passed++;
        pulse_reset();
    endtask

    task automatic test_reset_mid_mdu();
        int lat, st, sa, rt; bit bz, stb, ok; logic [63:0] opc, od; logic [31:0] rc;
        run_op(1'b0, 64'h100, 64'h1, 64'h0, 0, 0, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        wait_idle(ok);
        in_valid = 1'b1; in_is_mdu = 1'b1; in_pc = 64'h8000_0030;
        step();
        in_valid = 1'b0; in_is_mdu = 1'b0;
        total++; if (mdu_start !== 1'b1) $display("FAIL mid_start got %b want 1", mdu_start); else passed++;
        #3 rst = 1'b0;
        #1;
        total++; if (mdu_start !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || retire_cnt !== 32'd0 || out_pc !== 64'd0) $display("FAIL mid_reset got st=%b rdy=%b ov=%b rc=%0d pc=%h want all 0", mdu_start, in_ready, out_valid, retire_cnt, out_pc); else passed++;
        #3 rst = 1'b1;
        rc_model = 0;
        step();
        run_op(1'b0, 64'h200, 64'h77, 64'h0, 0, 0, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        rc_model++;
        total++; if (rc !== rc_model || od !== 64'h77) $display("FAIL post_reset got rc=%0d d=%h want %0d/77", rc, od, rc_model); else passed++;
    endtask

    task automatic test_timeout();
        int lat, st, sa, rt; bit bz, stb, ok; logic [63:0] opc, od; logic [31:0] rc;
`ifdef EXU_SEQ_TIMEOUT_EN
        int hc;
        wait_idle(ok);
        in_valid = 1'b1; in_is_mdu = 1'b1; in_pc = 64'h8000_0040;
        step();
        in_valid = 1'b0; in_is_mdu = 1'b0;
        hc = -1;
        for (int c = 1; c < 40; c++) begin
            if (halt === 1'b1) begin
                hc = c;
                break;
            end
            step();
        end
        total++; if (hc !== TMO + 1) $display("FAIL tmo_cycle got %0d want %0d", hc, TMO + 1); else passed++;
        total++; if (halt_abort !== 1'b1 || halt_pc !== 64'h8000_0040) $display("FAIL tmo_halt got %b/%h want 1/80000040", halt_abort, halt_pc); else passed++;
        pulse_reset();
        run_op(1'b1, 64'h8000_0048, 64'h0, 64'hBEEF, TMO - 1, 0, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        rc_model++;
        total++; if (lat !== TMO + 1 || od !== 64'hBEEF || halt !== 1'b0) $display("FAIL tmo_edge got lat=%0d d=%h h=%b want %0d/beef/0", lat, od, halt, TMO + 1); else passed++;
`else
        run_op(1'b1, 64'h8000_0050, 64'h0, 64'hF00D, 80, 0, 1'b0, lat, st, sa, rt, bz, stb, opc, od, rc);
        rc_model++;
        total++; if (lat !== 82 || od !== 64'hF00D || halt !== 1'b0) $display("FAIL long_mdu got lat=%0d d=%h h=%b want 82/f00d/0", lat, od, halt); else passed++;
`endif
        total++; if (rc !== rc_model) $display("FAIL tmo_retire got %0d want %0d", rc, rc_model); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mdu();
        test_backpressure();
        test_random();
        test_halt();
        test_reset_mid_mdu();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exu_sequencer.md
# exu_sequencer

Multi-cycle execution sequencer sitting between the IDU and WBU of the NPC core. It accepts one decoded instruction at a time over a valid/ready handshake, and routes it to one of two units: the single-cycle combinational ALU/EXU result, or a shared iterative multiply/divide unit (MDU) using a start/done handshake. It presents the result to writeback, and latches simulator halt conditions (ebreak, invalid instruction, MDU timeout) as sticky status.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: MDU cycles allowed before abort. Only used when `EXU_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: IDU has an instruction.
- `in_ready` output 1: sequencer accepts this cycle.
- `in_pc` input 64: instruction PC.
- `in_is_mdu` input 1: op needs the MDU.
- `in_ebreak` input 1: instruction is ebreak.
- `in_invalid` input 1: decoder flagged an invalid instruction.
- `alu_result` input 64: combinational EXU result for the current `in_*` instruction.
- `mdu_start` output 1: one-cycle start pulse to the MDU.
- `mdu_done` input 1: MDU result valid (single-cycle pulse).
- `mdu_result` input 64: MDU result, valid with `mdu_done`.
- `out_valid` output 1: result ready for the WBU.
- `out_ready` input 1: WBU accepts.
- `out_pc` output 64: PC of the presented result.
- `out_rd_data` output 64: result data.
- `halt` output 1: sticky halt flag.
- `halt_abort` output 1: 1 means abort (invalid instruction or timeout); 0 with `halt` means good ebreak.
- `halt_pc` output 64: PC of the halting instruction.
- `retire_cnt` output 32: count of results handed to the WBU.

## Operation
States: IDLE, WAIT_MDU, OUT, HALT. All outputs are 0 in reset, and the state resets to IDLE.

IDLE:
- `in_ready` = 1.
- On `in_valid` the instruction is accepted and `in_pc` is latched.
- Priority on accept: `in_invalid`, then `in_ebreak`, then `in_is_mdu`, then ALU.
- `in_invalid`: go to HALT with `halt_abort` = 1 and `halt_pc` = `in_pc`.
- `in_ebreak`: go to HALT with `halt_abort` = 0 and `halt_pc` = `in_pc`. Nothing is sent to the WBU.
- `in_is_mdu`: go to WAIT_MDU.
- Otherwise: latch `alu_result` into `out_rd_data` and go to OUT.

WAIT_MDU:
- `in_ready` = 0.
- `mdu_start` = 1 only in the first cycle of WAIT_MDU.
- `mdu_done` is ignored in the start cycle and sampled in every later cycle.
- On `mdu_done`: latch `mdu_result` and go to OUT.

OUT:
- `out_valid` = 1, and `out_pc`/`out_rd_data` are held stable until `out_ready`.
- On `out_valid && out_ready`: `retire_cnt` increments (wraps 0xFFFF_FFFF to 0) and the state returns to IDLE.

HALT:
- Absorbing until `rst` is asserted.
- `in_ready` = 0, `out_valid` = 0, `mdu_start` = 0.
- `halt`, `halt_abort` and `halt_pc` are held.

Other rules:
- `in_valid` while `in_ready` = 0 is not accepted. The IDU holds its inputs.
- `mdu_done` outside WAIT_MDU is ignored.
- Reset asserted mid-operation (WAIT_MDU or OUT) discards the instruction, clears all outputs, and does not retire.

## Timing
- ALU op accepted in cycle N: `out_valid` in cycle N+1. Minimum throughput is 1 instruction per 2 cycles (IDLE, then OUT).
- MDU op accepted in cycle N:
  - `mdu_start` in cycle N+1.
  - If `mdu_done` arrives in cycle N+1+k (k ≥ 1), `out_valid` follows in cycle N+2+k.
- HALT is entered in cycle N+1 after an accepted ebreak or invalid instruction. `halt` is asserted in that same cycle.
- `out_ready` held low stalls OUT indefinitely. No timeout applies in OUT.

## Configuration
- `EXU_SEQ_TIMEOUT_EN` defined:
  - A 16-bit counter clears on WAIT_MDU entry and increments each WAIT_MDU cycle.
  - If it reaches `TIMEOUT_CYCLES` without `mdu_done`, go to HALT with `halt_abort` = 1 and `halt_pc` = the latched PC.
  - `mdu_done` in the same cycle as the timeout wins (go to OUT).
- Not defined: no counter exists, and WAIT_MDU waits forever.

## Test plan
- ALU: `in_valid` with `in_pc` = 0x8000_0000 and `alu_result` = 0x1234, with `out_ready` = 1. Expect `out_valid` 1 cycle later with `out_rd_data` = 0x1234 and `out_pc` = 0x8000_0000, and `retire_cnt` 0 → 1.
- MDU: `in_is_mdu` = 1. Expect a single `mdu_start` pulse. Then `mdu_done` 5 cycles later with `mdu_result` = 0xDEAD. Expect `out_valid` the next cycle with 0xDEAD, and `in_ready` = 0 throughout.
- Backpressure: hold `out_ready` = 0 for 10 cycles. Expect `out_*` stable and `in_ready` = 0, then retire on the first `out_ready` = 1.
- Halt: `in_ebreak` at PC 0x8000_0010 gives `halt` = 1, `halt_abort` = 0, `halt_pc` = 0x8000_0010, with no `out_valid`. `in_invalid` gives `halt_abort` = 1. Further `in_valid` is ignored until reset.
- Timeout (macro on, `TIMEOUT_CYCLES` = 8): MDU op with no `mdu_done` gives HALT with `halt_abort` = 1. A second run with `mdu_done` on the timeout cycle gives a normal retire.
- Reset mid-WAIT_MDU: assert `rst` low asynchronously. All outputs go to 0 immediately, and `retire_cnt` = 0.
